ppa_sklansky_pipe: RTL
======================

PPA_SKLANSKY_PIPE -- requirements
Module: ppa_sklansky_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/sum width in bits; legal range 4..64.
REQ-002 Parameter LATENCY, default 2: in-to-out latency in clock cycles with no stall; legal range 1..4.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 cin  input  1  carry input.
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract (B inverted).
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 S  output  WIDTH  sum.
REQ-014 cout  output  1  carry out of MSB.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 op_count  output  16  count of results consumed downstream.

Function
REQ-017 Carry computation SHALL use a Sklansky parallel-prefix tree of ceil(log2(WIDTH)) levels on generate/propagate pairs; no ripple chain longer than one prefix cell.
REQ-018 Let Bx = sub ? ~B : B; {cout,S} SHALL equal A + Bx + cin, computed at WIDTH+1 bits.
REQ-019 ovf SHALL be 1 when A[MSB] == Bx[MSB] and S[MSB] != A[MSB]; else 0.
REQ-020 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-021 A result SHALL be consumed on a rising edge where out_valid && out_ready.
REQ-022 Pipeline SHALL hold exactly LATENCY register stages, each carrying a valid bit plus data; the first stage captures operands, the last stage drives S/cout/ovf; intermediate stages split the prefix levels as evenly as possible.
REQ-023 stall = out_valid && !out_ready; in_ready SHALL equal !stall (combinational).
REQ-024 When stall = 1, all stages SHALL hold their contents; when stall = 0, every stage SHALL advance one position per cycle, and a stage whose predecessor is empty SHALL load valid = 0.
REQ-025 Unstalled throughput SHALL be one result per cycle; result for a beat accepted at edge N SHALL appear with out_valid = 1 after edge N+LATENCY-1.
REQ-026 S, cout, ovf SHALL remain stable while out_valid && !out_ready.
REQ-027 When out_valid = 0, S/cout/ovf values are don't-care to the consumer, but SHALL not be X after reset.
REQ-028 Results SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-029 op_count SHALL increment by 1 on each consume (REQ-021) and wrap 16'hFFFF -> 16'h0000.
REQ-030 in_valid with in_ready = 0 SHALL NOT be accepted; upstream must hold the beat.
REQ-031 Simultaneous consume of the last-stage result and accept of a new beat SHALL both take effect in the same cycle.

Reset
REQ-032 While rst = 1: all stage valid bits, out_valid, S, cout, ovf and op_count SHALL be 0, asynchronously, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats; none reappears after release.
REQ-034 in_ready SHALL be 1 while rst = 1 and on the first cycle after release; no beat is accepted while rst = 1.

Verification
REQ-035 WIDTH=19, LATENCY=2, out_ready=1: A=19'h7FFFF, B=19'h00001, cin=0, sub=0 -> two cycles later S=0, cout=1, ovf=0, out_valid=1.
REQ-036 WIDTH=32, sub=1, cin=1: A=5, B=7 -> S=32'hFFFFFFFE, cout=0; A=32'h80000000, B=1 -> S=32'h7FFFFFFF, ovf=1.
REQ-037 Backpressure: stream 10 random beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, S is stable, all 10 results match {cout,S}=A+Bx+cin in order, op_count=10.
REQ-038 Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 and op_count=0 immediately; no stale result after release.
REQ-039 Sweep LATENCY 1..4 and WIDTH in {4,19,64} with 1000 random beats each, out_ready random -> zero mismatches vs. golden model; op_count wrap checked by forcing 65537 consumes.

Source files
------------

// File: rtl/ppa_sklansky_pipe_if.sv
// Handshaked operand/result bundle for the pipelined Sklansky adder.
// The master drives operands and result backpressure; the slave is the adder.
interface ppa_sklansky_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic [15:0]      op_count;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, S, cout, ovf, op_count
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, S, cout, ovf, op_count
  );
endinterface

// File: rtl/ppa_sklansky_pipe.sv
// Pipelined add/subtract built on a Sklansky parallel-prefix carry tree.
// Prefix levels are spread evenly over LATENCY stages; a stall freezes every stage.
module ppa_sklansky_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  ppa_sklansky_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int TOP    = LATENCY - 1;

  // Applies prefix levels [lo, hi) to group generate/propagate; returns {p, g}.
  function automatic logic [2*WIDTH-1:0] prefix_span(
    input logic [WIDTH-1:0] g_i,
    input logic [WIDTH-1:0] p_i,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] g, p, gn, pn;
    int j;
    g = g_i;
    p = p_i;
    for (int l = 0; l < LEVELS; l++) begin
      if (l >= lo && l < hi) begin
        gn = g;
        pn = p;
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> l) & 1) == 1) begin
            j     = ((i >> l) << l) - 1;
            gn[i] = g[i] | (p[i] & g[j]);
            pn[i] = p[i] & p[j];
          end
        end
        g = gn;
        p = pn;
      end
    end
    return {p, g};
  endfunction

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g_in  [LATENCY];
  logic [WIDTH-1:0] p_in  [LATENCY];
  logic [WIDTH-1:0] x_in  [LATENCY];
  logic             cin_in   [LATENCY];
  logic             valid_in [LATENCY];
  logic [WIDTH-1:0] g_next [LATENCY];
  logic [WIDTH-1:0] p_next [LATENCY];

  logic [WIDTH-1:0] g_reg [LATENCY];
  logic [WIDTH-1:0] p_reg [LATENCY];
  logic [WIDTH-1:0] x_reg [LATENCY];
  logic             cin_reg   [LATENCY];
  logic             valid_reg [LATENCY];
  logic [15:0]      op_count_reg;
  logic             stall;

  always_comb begin
    bx = bus.sub ? ~bus.B : bus.B;
    // Folding cin into bit 0's generate makes G[i] the carry out of bit i.
    x_in[0]     = bus.A ^ bx;
    p_in[0]     = bus.A ^ bx;
    g_in[0]     = (bus.A & bx) | WIDTH'(bus.cin & (bus.A[0] ^ bx[0]));
    cin_in[0]   = bus.cin;
    valid_in[0] = bus.in_valid;
    for (int k = 1; k < LATENCY; k++) begin
      g_in[k]     = g_reg[k-1];
      p_in[k]     = p_reg[k-1];
      x_in[k]     = x_reg[k-1];
      cin_in[k]   = cin_reg[k-1];
      valid_in[k] = valid_reg[k-1];
    end
    for (int k = 0; k < LATENCY; k++) begin
      {p_next[k], g_next[k]} = prefix_span(g_in[k], p_in[k],
                                           (k * LEVELS) / LATENCY,
                                           ((k + 1) * LEVELS) / LATENCY);
    end
  end

  assign stall = valid_reg[TOP] && !bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        g_reg[k]     <= '0;
        p_reg[k]     <= '0;
        x_reg[k]     <= '0;
        cin_reg[k]   <= 1'b0;
        valid_reg[k] <= 1'b0;
      end
      op_count_reg <= 16'h0000;
    end else begin
      if (!stall) begin
        for (int k = 0; k < LATENCY; k++) begin
          g_reg[k]     <= g_next[k];
          p_reg[k]     <= p_next[k];
          x_reg[k]     <= x_in[k];
          cin_reg[k]   <= cin_in[k];
          valid_reg[k] <= valid_in[k];
        end
      end
      if (valid_reg[TOP] && bus.out_ready) begin
        op_count_reg <= op_count_reg + 16'd1;
      end
    end
  end

  // Carry into bit i is the resolved group generate of bits i-1..0.
  assign bus.in_ready  = !stall;
  assign bus.out_valid = valid_reg[TOP];
  assign bus.S         = x_reg[TOP] ^ {g_reg[TOP][WIDTH-2:0], cin_reg[TOP]};
  assign bus.cout      = g_reg[TOP][WIDTH-1];
  assign bus.ovf       = g_reg[TOP][WIDTH-1] ^ g_reg[TOP][WIDTH-2];
  assign bus.op_count  = op_count_reg;
endmodule
